// File: rtl/secded_scrub_memory_if.sv
// Request/response bundle between the system bus and the SEC-DED scrub memory.
interface secded_scrub_memory_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 8
);
  // Smallest Hamming parity count covering DATA_W data bits.
  function automatic int unsigned calc_p(input int unsigned dw);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < (dw + r + 1)) r = r + 1;
    return r;
  endfunction

  localparam int unsigned P    = calc_p(DATA_W);
  localparam int unsigned CW_W = DATA_W + P + 1;

  logic              req_ready;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [CW_W-1:0]   inj_mask;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              single_err;
  logic              double_err;
  logic              cnt_clr;
  logic [CNT_W-1:0]  corr_cnt;
  logic [CNT_W-1:0]  uncorr_cnt;

  modport master (
    input  req_ready, rd_data, rd_valid, single_err, double_err, corr_cnt, uncorr_cnt,
    output wr_en, rd_en, addr, wr_data, inj_mask, cnt_clr
  );

  modport slave (
    output req_ready, rd_data, rd_valid, single_err, double_err, corr_cnt, uncorr_cnt,
    input  wr_en, rd_en, addr, wr_data, inj_mask, cnt_clr
  );
endinterface

// File: rtl/secded_scrub_memory.sv
// SEC-DED protected memory with single-cycle reads, user write-back of corrected
// words, a background scrubber and saturating error counters.
module secded_scrub_memory #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned SCRUB_EN       = 1,
  parameter int unsigned SCRUB_INTERVAL = 64,
  parameter int unsigned CNT_W          = 8
) (
  input logic                  clk,
  input logic                  rst,
  secded_scrub_memory_if.slave bus
);
  function automatic int unsigned calc_p(input int unsigned dw);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < (dw + r + 1)) r = r + 1;
    return r;
  endfunction

  localparam int unsigned P        = calc_p(DATA_W);
  localparam int unsigned CW_W     = DATA_W + P + 1;
  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam int unsigned TMR_W    = $clog2(SCRUB_INTERVAL);
  localparam int unsigned CW_IDX_W = $clog2(CW_W);
  localparam int unsigned D_IDX_W  = $clog2(DATA_W);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(SCRUB_INTERVAL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, SCRUB_RD, SCRUB_CHK, SCRUB_WB, USER_WB} state_t;

  // Hamming syndrome: XOR of the positions of all set bits 1..N.
  function automatic logic [P-1:0] syndrome(input logic [CW_W-1:0] cw);
    logic [P-1:0] s;
    s = '0;
    for (int unsigned pos = 1; pos < CW_W; pos++)
      if (cw[CW_IDX_W'(pos)]) s = s ^ P'(pos);
    return s;
  endfunction

  // Data LSB-first into non-power-of-two positions, then parity, then overall parity.
  function automatic logic [CW_W-1:0] enc(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] cw;
    logic [P-1:0]    s;
    logic [P-1:0]    sh;
    int unsigned     k;
    cw = '0;
    k  = 0;
    for (int unsigned pos = 1; pos < CW_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[CW_IDX_W'(pos)] = d[D_IDX_W'(k)];
        k = k + 1;
      end
    end
    s = syndrome(cw);
    for (int unsigned i = 0; i < P; i++) begin
      sh = s >> i;
      cw[CW_IDX_W'(32'd1 << i)] = sh[0];
    end
    cw[0] = ^cw[CW_W-1:1];
    return cw;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    int unsigned       k;
    d = '0;
    k = 0;
    for (int unsigned pos = 1; pos < CW_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[D_IDX_W'(k)] = cw[CW_IDX_W'(pos)];
        k = k + 1;
      end
    end
    return d;
  endfunction

  // Flip the bit named by the syndrome; zero syndrome means the overall parity bit.
  function automatic logic [CW_W-1:0] fix(input logic [CW_W-1:0] cw, input logic [P-1:0] syn);
    logic [CW_W-1:0] f;
    f = cw;
    if (syn == '0) f[0] = ~f[0];
    else
      for (int unsigned pos = 1; pos < CW_W; pos++)
        if (syn == P'(pos)) f[CW_IDX_W'(pos)] = ~f[CW_IDX_W'(pos)];
    return f;
  endfunction

  logic [CW_W-1:0]   mem [DEPTH];
  state_t            state, state_next;
  logic [TMR_W-1:0]  timer;
  logic [ADDR_W-1:0] scrub_addr, wb_addr;
  logic [CW_W-1:0]   scrub_word, wb_word;

  logic              acc_c, wr_acc_c, rd_acc_c, scrub_adv_c;
  logic [CW_W-1:0]   u_cw, u_fix, s_fix;
  logic [P-1:0]      u_syn, s_syn;
  logic              u_single, u_double, s_single, s_double;
  logic [DATA_W-1:0] u_data;
  logic              corr_inc_c, unc_inc_c;

  // Request acceptance and decode of both the user and scrub read paths.
  always_comb begin
    acc_c      = bus.req_ready & (bus.wr_en | bus.rd_en);
    wr_acc_c   = bus.req_ready & bus.wr_en;
    rd_acc_c   = bus.req_ready & bus.rd_en & ~bus.wr_en;
    u_cw       = mem[bus.addr];
    u_syn      = syndrome(u_cw);
    u_single   = ^u_cw;
    u_double   = (u_syn != '0) && !u_single;
    u_fix      = fix(u_cw, u_syn);
    u_data     = extract(u_single ? u_fix : u_cw);
    s_syn      = syndrome(scrub_word);
    s_single   = ^scrub_word;
    s_double   = (s_syn != '0) && !s_single;
    s_fix      = fix(scrub_word, s_syn);
    corr_inc_c = (rd_acc_c & u_single) | ((state == SCRUB_CHK) & s_single);
    unc_inc_c  = (rd_acc_c & u_double) | ((state == SCRUB_CHK) & s_double);
  end

  // FSM next state; a user request in IDLE always beats a due scrub.
  always_comb begin
    state_next  = state;
    scrub_adv_c = 1'b0;
    case (state)
      IDLE: begin
        if (rd_acc_c && u_single) state_next = USER_WB;
        else if (SCRUB_EN != 0 && !acc_c && timer == TMR_MAX) state_next = SCRUB_RD;
      end
      SCRUB_RD:  state_next = SCRUB_CHK;
      SCRUB_CHK: begin
        if (s_single) state_next = SCRUB_WB;
        else begin
          state_next  = IDLE;
          scrub_adv_c = 1'b1;
        end
      end
      SCRUB_WB: begin
        state_next  = IDLE;
        scrub_adv_c = 1'b1;
      end
      USER_WB:  state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Storage array: user writes and corrected write-backs never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[ADDR_W'(i)] <= '0;
    end else if (wr_acc_c) begin
      mem[bus.addr] <= enc(bus.wr_data) ^ bus.inj_mask;
    end else if (state == USER_WB || state == SCRUB_WB) begin
      mem[wb_addr] <= wb_word;
    end
  end

  // Scrubber bookkeeping and pending write-back capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer      <= '0;
      scrub_addr <= '0;
      scrub_word <= '0;
      wb_word    <= '0;
      wb_addr    <= '0;
    end else begin
      if (state != IDLE || state_next != IDLE) timer <= '0;
      else if (timer != TMR_MAX)               timer <= timer + TMR_W'(1);
      if (scrub_adv_c)        scrub_addr <= scrub_addr + ADDR_W'(1);
      if (state == SCRUB_RD)  scrub_word <= mem[scrub_addr];
      if (rd_acc_c && u_single) begin
        wb_word <= u_fix;
        wb_addr <= bus.addr;
      end else if (state == SCRUB_CHK && s_single) begin
        wb_word <= s_fix;
        wb_addr <= scrub_addr;
      end
    end
  end

  // Registered read response and request-ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.req_ready  <= 1'b1;
      bus.rd_valid   <= 1'b0;
      bus.rd_data    <= '0;
      bus.single_err <= 1'b0;
      bus.double_err <= 1'b0;
    end else begin
      bus.req_ready  <= (state_next == IDLE);
      bus.rd_valid   <= rd_acc_c;
      bus.single_err <= rd_acc_c & u_single;
      bus.double_err <= rd_acc_c & u_double;
      if (rd_acc_c) bus.rd_data <= u_data;
    end
  end

  // Saturating error counters; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr) begin
      bus.corr_cnt   <= '0;
      bus.uncorr_cnt <= '0;
    end else begin
      if (corr_inc_c && bus.corr_cnt != CNT_MAX)  bus.corr_cnt   <= bus.corr_cnt + CNT_W'(1);
      if (unc_inc_c && bus.uncorr_cnt != CNT_MAX) bus.uncorr_cnt <= bus.uncorr_cnt + CNT_W'(1);
    end
  end
endmodule
